// File: rtl/csa_n.sv
// N-bit carry-select adder, {co, s} = a + b + ci, partitioned into BLK-bit blocks.
// Define CSA_N_REG_OUT_EN to register s/co (1-cycle latency, sync reset); otherwise purely combinational.
module csa_n #(
  parameter int N   = 4,
  parameter int BLK = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  localparam int NB = (N + BLK - 1) / BLK;

  // Full-adder cell: returns {carry, sum}.
  function automatic logic [1:0] fa(input logic x, input logic y, input logic c);
    return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

  logic [N-1:0] sum_c;
  logic [NB:0]  blk_c;

  assign blk_c[0] = ci;

  for (genvar k = 0; k < NB; k++) begin : g_blk
    localparam int LO = k * BLK;
    localparam int W  = (N - LO < BLK) ? (N - LO) : BLK;

    logic [W-1:0] x, y, s0;
    logic [W:0]   c0;

    assign x = a[LO +: W];
    assign y = b[LO +: W];

    if (k == 0) begin : g_first
      // Block 0 ripples straight from ci; it is the only block on the true ripple path.
      assign c0[0] = ci;
      for (genvar j = 0; j < W; j++) begin : g_bit
        assign {c0[j+1], s0[j]} = fa(x[j], y[j], c0[j]);
      end
      assign sum_c[LO +: W] = s0;
      assign blk_c[k+1]     = c0[W];
    end else begin : g_sel
      logic [W-1:0] s1;
      logic [W:0]   c1;

      assign c0[0] = 1'b0;
      assign c1[0] = 1'b1;
      for (genvar j = 0; j < W; j++) begin : g_bit
        assign {c0[j+1], s0[j]} = fa(x[j], y[j], c0[j]);
        assign {c1[j+1], s1[j]} = fa(x[j], y[j], c1[j]);
      end
      // Incoming block carry picks the precomputed result; only this mux chain is serial.
      assign sum_c[LO +: W] = blk_c[k] ? s1 : s0;
      assign blk_c[k+1]     = blk_c[k] ? c1[W] : c0[W];
    end
  end

`ifdef CSA_N_REG_OUT_EN
  logic [N-1:0] s_d, s_q;
  logic         co_d, co_q;

  assign s_d  = sum_c;
  assign co_d = blk_c[NB];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q  <= '0;
      co_q <= 1'b0;
    end else begin
      s_q  <= s_d;
      co_q <= co_d;
    end
  end

  assign s  = s_q;
  assign co = co_q;
`else
  // Clock and reset are kept as ports for a uniform footprint but play no part here.
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, rst};

  assign s  = sum_c;
  assign co = blk_c[NB];
`endif

endmodule

// File: tb/tb_csa_n.sv
// Self-checking bench for csa_n: N=4/BLK=2 and N=8/BLK=3 instances, directed tables plus exhaustive N=4 sweep.
// Follows CSA_N_REG_OUT_EN: when defined, results are sampled one clock after the operands are applied.
module tb_csa_n;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic [3:0] s;
    logic       co;
  } vec4_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
  } vec8_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a4 = '0, b4 = '0, s4;
  logic       ci4 = 1'b0, co4;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic       ci8 = 1'b0, co8;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  csa_n #(.N(4), .BLK(2)) dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .ci(ci4), .s(s4), .co(co4)
  );

  csa_n #(.N(8), .BLK(3)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .ci(ci8), .s(s8), .co(co8)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive operands away from the clock edge, then wait until the result is observable.
  task automatic wait_result();
`ifdef CSA_N_REG_OUT_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic apply4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    @(negedge clk);
    a4 = a; b4 = b; ci4 = ci;
    wait_result();
  endtask

  task automatic apply8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    @(negedge clk);
    a8 = a; b8 = b; ci8 = ci;
    wait_result();
  endtask

  vec4_t t4[7];
  vec8_t t8[7];

  initial begin
    t4[0] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1};  // full propagate
    t4[1] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};  // all-ones boundary
    t4[2] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};  // all-zero boundary
    t4[3] = '{4'h9, 4'h8, 1'b0, 4'h1, 1'b1};
    t4[4] = '{4'h5, 4'hA, 1'b0, 4'hF, 1'b0};
    t4[5] = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0};  // carry into block 1 only
    t4[6] = '{4'h3, 4'hC, 1'b1, 4'h0, 1'b1};

    t8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    t8[1] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1};
    t8[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    t8[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    t8[4] = '{8'h07, 8'h01, 1'b0, 8'h08, 1'b0};  // crosses block 0 -> 1
    t8[5] = '{8'h3F, 8'h01, 1'b0, 8'h40, 1'b0};  // crosses into narrow top block
    t8[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

    // Reset behaviour.
    @(negedge clk);
    rst = 1'b1;
    a4 = 4'h3; b4 = 4'h4; ci4 = 1'b0;
    a8 = 8'h10; b8 = 8'h20; ci8 = 1'b1;
    @(posedge clk);
    #1;
`ifdef CSA_N_REG_OUT_EN
    check("reset_s4", 64'(s4), 64'h0);
    check("reset_co4", 64'(co4), 64'h0);
    check("reset_s8", 64'(s8), 64'h0);
`else
    check("rst_ignored_s4", 64'(s4), 64'h7);
    check("rst_ignored_co4", 64'(co4), 64'h0);
    check("rst_ignored_s8", 64'(s8), 64'h31);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      apply4(t4[i].a, t4[i].b, t4[i].ci);
      check($sformatf("vec4_%0d_s", i), 64'(s4), 64'(t4[i].s));
      check($sformatf("vec4_%0d_co", i), 64'(co4), 64'(t4[i].co));
    end

    for (int i = 0; i < 7; i++) begin
      apply8(t8[i].a, t8[i].b, t8[i].ci);
      check($sformatf("vec8_%0d_s", i), 64'(s8), 64'(t8[i].s));
      check($sformatf("vec8_%0d_co", i), 64'(co8), 64'(t8[i].co));
    end

    // Exhaustive N=4 sweep, ci=0 first then ci=1.
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) begin
          logic [4:0] exp_sum;
          exp_sum = 5'(i) + 5'(j) + 5'(c);
          apply4(4'(i), 4'(j), 1'(c));
          check($sformatf("exh_%0d_%0d_%0d", i, j, c), 64'({co4, s4}), 64'(exp_sum));
        end
      end
    end

`ifdef CSA_N_REG_OUT_EN
    // Latency, reset override and recovery.
    apply4(4'h9, 4'h8, 1'b0);
    check("lat_s", 64'(s4), 64'h1);
    check("lat_co", 64'(co4), 64'h1);
    @(negedge clk);
    a4 = 4'h1; b4 = 4'h1;
    #1;
    check("hold_before_edge", 64'({co4, s4}), 64'h11);
    a4 = 4'h9; b4 = 4'h8;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_override_s", 64'(s4), 64'h0);
    check("rst_override_co", 64'(co4), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("resume_s", 64'(s4), 64'h1);
    check("resume_co", 64'(co4), 64'h1);
`else
    // Reset toggling must not disturb the combinational result.
    apply4(4'h9, 4'h8, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("comb_rst_s", 64'(s4), 64'h1);
    check("comb_rst_co", 64'(co4), 64'h1);
    @(negedge clk);
    rst = 1'b0;
    a4 = 4'hE; b4 = 4'h3; ci4 = 1'b1;
    #1;
    check("comb_zero_latency", 64'({co4, s4}), 64'h12);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/csa_n.md
CSA_N -- requirements
Module: csa_n

Interface
REQ-001 Parameter N, default 4: operand and sum width in bits; legal range 1..64.
REQ-002 Parameter BLK, default 2: carry-select block width in bits; legal range 1..N.
REQ-003 clk  input  1  single clock, rising-edge active.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 a    input  N  addend A, unsigned.
REQ-006 b    input  N  addend B, unsigned.
REQ-007 ci   input  1  carry in.
REQ-008 s    output N  sum bits.
REQ-009 co   output 1  carry out.

Function
REQ-010 The block SHALL produce {co, s} = a + b + ci, computed at N+1 bits, with no truncation of the carry.
REQ-011 The datapath SHALL be partitioned into ceil(N/BLK) blocks, with bits [BLK-1:0] as block 0.
REQ-012 If N is not a multiple of BLK, the final block SHALL be narrower and hold the remaining high bits.
REQ-013 Block 0 SHALL be a ripple-carry adder driven directly by ci.
REQ-014 Each block k>0 SHALL contain two ripple-carry adders, one with carry-in 0 and one with carry-in 1, computing both results in parallel.
REQ-015 In each block k>0, the carry out of block k-1 SHALL select that block's sum bits and carry out through a 2:1 multiplexer.
REQ-016 co SHALL be the selected carry out of the final block.
REQ-017 Each ripple adder SHALL be built from full-adder cells: sum = x^y^c; carry = x&y | c&(x^y).
REQ-018 Worst-case propagate (a=all ones, b=0, ci=1) SHALL ripple through block 0 only, then through the mux chain.
REQ-019 Boundary: all-ones + all-ones + 1 SHALL give s = all ones, co = 1.
REQ-020 Boundary: all-zero inputs SHALL give s = 0, co = 0.
REQ-021 Output timing depends on the configuration macro (REQ-025 to REQ-027).

Reset
REQ-022 With outputs registered, rst high at a rising clk edge SHALL set s = 0 and co = 0 at that edge, overriding the computed result.
REQ-023 Outputs SHALL resume tracking the inputs at the first rising edge after rst deasserts.
REQ-024 In combinational mode, rst SHALL have no effect on s or co.

Configuration
REQ-025 The macro is CSA_N_REG_OUT_EN.
REQ-026 With CSA_N_REG_OUT_EN defined:
- s and co SHALL be registered on the rising edge of clk.
- Latency SHALL be exactly 1 cycle: the result for inputs sampled at edge t appears after edge t.
- New operands are accepted every cycle.
REQ-027 With CSA_N_REG_OUT_EN undefined:
- s and co SHALL be purely combinational, with zero latency.
- There SHALL be no storage elements.
- clk and rst SHALL remain as ports but be unused.

Verification
REQ-028 Exhaustive test, N=4, BLK=2, macro undefined: all 16x16 pairs of a and b, first with ci=0 and then with ci=1 -> every case gives {co,s} == a+b+ci, err never asserted.
REQ-029 a=4'hF, b=4'h0, ci=1 -> s=4'h0, co=1 (full propagate across blocks).
REQ-030 a=4'hF, b=4'hF, ci=1 -> s=4'hF, co=1; a=0, b=0, ci=0 -> s=0, co=0.
REQ-031 N=8, BLK=3 (uneven final block): a=8'hFF, b=8'h01, ci=0 -> s=8'h00, co=1; a=8'h5A, b=8'hA5, ci=1 -> s=8'h00, co=1.
REQ-032 Macro defined, a=4'h9, b=4'h8, ci=0 applied before edge t:
- After edge t -> s=4'h1, co=1.
- With rst=1 at edge t+1 -> s=0, co=0.
- After rst deasserts -> result returns at the next edge.
